// File: rtl/userio_joy_pkg.sv
// Shared definitions for the DB15 user-I/O joystick scanner.
//   - scan_state_t : scanner FSM states
//   - JB_*         : bit positions inside a published joystick word
//   - FRAME_BITS   : serial bits per frame (two chained 16-bit registers)
//   - PLAYER_BITS  : width of one published joystick word
package userio_joy_pkg;

    typedef enum logic [1:0] {
        S_LOAD,
        S_SHIFT,
        S_COMMIT,
        S_GAP
    } scan_state_t;

    localparam int FRAME_BITS  = 32;
    localparam int PLAYER_BITS = 16;
    localparam int JOY_BUTTONS = 12;  // used bits per player, rest of the word is zero
    localparam int P2_BASE     = 16;  // player 2 starts at stream bit 16

    localparam int JB_R      = 0;
    localparam int JB_L      = 1;
    localparam int JB_D      = 2;
    localparam int JB_U      = 3;
    localparam int JB_A      = 4;
    localparam int JB_B      = 5;
    localparam int JB_C      = 6;
    localparam int JB_BTN_D  = 7;
    localparam int JB_E      = 8;
    localparam int JB_F      = 9;
    localparam int JB_START  = 10;
    localparam int JB_SELECT = 11;

endpackage

// File: rtl/userio_db15_scanner_if.sv
// Adapter bus plus published joystick words of the DB15 scanner.
//   joy_data     : serial data from the adapter (active-low buttons)
//   joy_clk      : serial shift clock to the adapter
//   joy_load     : parallel load to the adapter, active-low
//   joystick1/2  : published active-high joystick words
//   present      : adapter seen in the last published frame
//   frame_strobe : one-clock pulse when the published values update
// master = scanner side, slave = adapter / consumer side.
interface userio_db15_scanner_if;
    import userio_joy_pkg::*;

    logic                   joy_data;
    logic                   joy_clk;
    logic                   joy_load;
    logic [PLAYER_BITS-1:0] joystick1;
    logic [PLAYER_BITS-1:0] joystick2;
    logic                   present;
    logic                   frame_strobe;

    modport master (
        input  joy_data,
        output joy_clk,
        output joy_load,
        output joystick1,
        output joystick2,
        output present,
        output frame_strobe
    );

    modport slave (
        output joy_data,
        input  joy_clk,
        input  joy_load,
        input  joystick1,
        input  joystick2,
        input  present,
        input  frame_strobe
    );
endinterface

// File: rtl/userio_tick_div.sv
// Free-running tick generator for the scanner.
//   clk   : joystick clock
//   reset : synchronous, active-high; clears the counter
//   tick  : high for one clock every CLK_DIV clocks; the first tick is
//           acted upon CLK_DIV clocks after reset deasserts
module userio_tick_div #(
    parameter int CLK_DIV = 12
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (cnt_reg == LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // Tick is the wrap condition, so logic gated by it acts on the wrap edge.
    assign tick = (cnt_reg == LAST);
endmodule

// File: rtl/userio_db15_scanner.sv
// DB15 arcade-stick scanner: clocks two chained 74HC165 registers, samples
// 32 active-low bits per frame, optionally requires two identical frames
// before publishing, and presents two active-high ----LS FEDCBAUDLR words.
//   clk   : joystick clock (40-50 MHz)
//   reset : synchronous, active-high
//   bus   : master modport of userio_db15_scanner_if (adapter lines and
//           published joystick1/joystick2/present/frame_strobe)
module userio_db15_scanner
    import userio_joy_pkg::*;
#(
    parameter int CLK_DIV   = 12,
    parameter int GAP_TICKS = 64,
    parameter int FILTER    = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    userio_db15_scanner_if.master  bus
);
    localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TICKS - 1);

    logic tick;

    userio_tick_div #(.CLK_DIV(CLK_DIV)) u_tick_div (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // joy_data is asynchronous to clk
    logic sync1_reg, sync2_reg;

    scan_state_t            state_reg,    state_next;
    logic                   load_cnt_reg, load_cnt_next;
    logic [4:0]             bit_reg,      bit_next;
    logic                   phase_reg,    phase_next;
    logic [GAP_W-1:0]       gap_reg,      gap_next;
    logic [FRAME_BITS-1:0]  raw_reg,      raw_next;
    logic [FRAME_BITS-1:0]  prev_reg,     prev_next;
    logic                   joy_clk_reg,  joy_clk_next;
    logic                   joy_load_reg, joy_load_next;
    logic [PLAYER_BITS-1:0] joy1_reg,     joy1_next;
    logic [PLAYER_BITS-1:0] joy2_reg,     joy2_next;
    logic                   present_reg,  present_next;
    logic                   strobe_reg,   strobe_next;

    // Decoded words of the frame currently held in raw_reg.
    logic [PLAYER_BITS-1:0] p1_word, p2_word;

    genvar gi;
    generate
        for (gi = 0; gi < PLAYER_BITS; gi++) begin : g_word
            if (gi < JOY_BUTTONS) begin : g_btn
                assign p1_word[gi] = ~raw_reg[gi];
                assign p2_word[gi] = ~raw_reg[P2_BASE + gi];
            end else begin : g_pad
                assign p1_word[gi] = 1'b0;
                assign p2_word[gi] = 1'b0;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg    <= 1'b1;
            sync2_reg    <= 1'b1;
            state_reg    <= S_LOAD;
            load_cnt_reg <= 1'b0;
            bit_reg      <= '0;
            phase_reg    <= 1'b0;
            gap_reg      <= '0;
            raw_reg      <= '0;
            prev_reg     <= '1;
            joy_clk_reg  <= 1'b0;
            joy_load_reg <= 1'b1;
            joy1_reg     <= '0;
            joy2_reg     <= '0;
            present_reg  <= 1'b0;
            strobe_reg   <= 1'b0;
        end else begin
            sync1_reg    <= bus.joy_data;
            sync2_reg    <= sync1_reg;
            state_reg    <= state_next;
            load_cnt_reg <= load_cnt_next;
            bit_reg      <= bit_next;
            phase_reg    <= phase_next;
            gap_reg      <= gap_next;
            raw_reg      <= raw_next;
            prev_reg     <= prev_next;
            joy_clk_reg  <= joy_clk_next;
            joy_load_reg <= joy_load_next;
            joy1_reg     <= joy1_next;
            joy2_reg     <= joy2_next;
            present_reg  <= present_next;
            strobe_reg   <= strobe_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        load_cnt_next = load_cnt_reg;
        bit_next      = bit_reg;
        phase_next    = phase_reg;
        gap_next      = gap_reg;
        raw_next      = raw_reg;
        prev_next     = prev_reg;
        joy_clk_next  = joy_clk_reg;
        joy_load_next = joy_load_reg;
        joy1_next     = joy1_reg;
        joy2_next     = joy2_reg;
        present_next  = present_reg;
        strobe_next   = 1'b0;

        case (state_reg)
            S_LOAD: begin
                if (tick) begin
                    if (joy_load_reg) begin
                        // Only after reset: load is still high, so the
                        // first tick asserts it and starts the 2-tick count.
                        joy_load_next = 1'b0;
                        load_cnt_next = 1'b0;
                    end else if (load_cnt_reg) begin
                        joy_load_next = 1'b1;
                        state_next    = S_SHIFT;
                        bit_next      = '0;
                        phase_next    = 1'b0;
                    end else begin
                        load_cnt_next = 1'b1;
                    end
                end
            end

            S_SHIFT: begin
                if (tick) begin
                    if (!phase_reg) begin
                        // Sample before the rising edge that advances the chain.
                        raw_next[bit_reg] = sync2_reg;
                        joy_clk_next      = 1'b1;
                        phase_next        = 1'b1;
                    end else begin
                        joy_clk_next = 1'b0;
                        if (bit_reg == 5'd31) begin
                            state_next = S_COMMIT;
                        end else begin
                            bit_next   = bit_reg + 5'd1;
                            phase_next = 1'b0;
                        end
                    end
                end
            end

            S_COMMIT: begin
                if ((FILTER == 0) || (raw_reg == prev_reg)) begin
                    if (raw_reg == '0) begin
                        // All-low frame: line floating or shorted, no adapter.
                        joy1_next    = '0;
                        joy2_next    = '0;
                        present_next = 1'b0;
                    end else begin
                        joy1_next    = p1_word;
                        joy2_next    = p2_word;
                        present_next = 1'b1;
                    end
                    strobe_next = 1'b1;
                end
                prev_next  = raw_reg;
                gap_next   = '0;
                state_next = S_GAP;
            end

            S_GAP: begin
                if (tick) begin
                    if (gap_reg == GAP_LAST) begin
                        state_next    = S_LOAD;
                        joy_load_next = 1'b0;
                        load_cnt_next = 1'b0;
                    end else begin
                        gap_next = gap_reg + 1'b1;
                    end
                end
            end

            default: state_next = S_LOAD;
        endcase
    end

    assign bus.joy_clk      = joy_clk_reg;
    assign bus.joy_load     = joy_load_reg;
    assign bus.joystick1    = joy1_reg;
    assign bus.joystick2    = joy2_reg;
    assign bus.present      = present_reg;
    assign bus.frame_strobe = strobe_reg;
endmodule

// File: tb/tb_userio_db15_scanner.sv
// Bench for userio_db15_scanner: one FILTER=1 and one FILTER=0 instance run
// in lockstep from a shared 74HC165 adapter model; expected frame results
// are queued when a frame's pattern is latched and compared at the next load.
module tb_userio_db15_scanner;
    import userio_joy_pkg::*;

    localparam int CLK_DIV   = 4;
    localparam int GAP_TICKS = 4;
    localparam int NPAT      = 21;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic joy_data_drv = 1'b1;

    userio_db15_scanner_if bus1 ();
    userio_db15_scanner_if bus0 ();

    assign bus1.joy_data = joy_data_drv;
    assign bus0.joy_data = joy_data_drv;

    userio_db15_scanner #(.CLK_DIV(CLK_DIV), .GAP_TICKS(GAP_TICKS), .FILTER(1)) dut_f1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    userio_db15_scanner #(.CLK_DIV(CLK_DIV), .GAP_TICKS(GAP_TICKS), .FILTER(0)) dut_f0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        s1;
        logic [15:0] a1;
        logic [15:0] b1;
        logic        p1;
        logic        s0;
        logic [15:0] a0;
        logic [15:0] b0;
        logic        p0;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;

    logic [31:0] next_pattern;
    logic [31:0] pat [NPAT];

    // reference state of the two scanners
    logic [31:0] prev1;
    logic [15:0] m1a, m1b, m0a, m0b;
    logic        m1p, m0p;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic reset_model();
        prev1 = '1;
        m1a = '0; m1b = '0; m1p = 1'b0;
        m0a = '0; m0b = '0; m0p = 1'b0;
    endtask

    task automatic push_frame(input logic [31:0] raw);
        exp_t e;
        logic [15:0] wa, wb;
        logic pr;
        pr = (raw != 32'h0);
        wa = pr ? {4'h0, ~raw[11:0]} : 16'h0;
        wb = pr ? {4'h0, ~raw[27:16]} : 16'h0;
        e.s1 = (raw == prev1);
        if (e.s1) begin
            m1a = wa; m1b = wb; m1p = pr;
        end
        prev1 = raw;
        e.s0 = 1'b1;
        m0a = wa; m0b = wb; m0p = pr;
        e.a1 = m1a; e.b1 = m1b; e.p1 = m1p;
        e.a0 = m0a; e.b0 = m0b; e.p0 = m0p;
        exp_q.push_back(e);
    endtask

    // Wait until joy_clk (use_clk=1) or joy_load reaches lvl; n = clocks waited.
    task automatic wait_sig(input bit use_clk, input logic lvl, output int n);
        logic v;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            v = use_clk ? bus1.joy_clk : bus1.joy_load;
        end while (v !== lvl && n < 3000);
        if (v !== lvl) check_val(use_clk ? "wait_joy_clk" : "wait_joy_load", {31'h0, v}, {31'h0, lvl});
    endtask

    // 74HC165 chain model: latch while load is low, shift on joy_clk rise.
    logic [31:0] shreg = '1;
    logic        jclk_prev = 1'b0;
    always @(negedge clk) begin
        if (!bus1.joy_load) begin
            shreg = next_pattern;
        end else if (bus1.joy_clk && !jclk_prev) begin
            shreg = {1'b1, shreg[31:1]};
        end
        jclk_prev = bus1.joy_clk;
        joy_data_drv = shreg[0];
    end

    // Scoreboard: a frame's results are complete before the next load falls.
    logic load_prev = 1'b1;
    logic seen1 = 1'b0;
    logic seen0 = 1'b0;
    int   frame_no = 0;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            seen1 = 1'b0;
            seen0 = 1'b0;
            load_prev = 1'b1;
        end else begin
            if (bus1.frame_strobe) seen1 = 1'b1;
            if (bus0.frame_strobe) seen0 = 1'b1;
            if (load_prev && !bus1.joy_load) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    $display("frame %0d: f1 strobe=%0b j1=%h j2=%h pr=%0b | f0 strobe=%0b j1=%h j2=%h pr=%0b",
                             frame_no, seen1, bus1.joystick1, bus1.joystick2, bus1.present,
                             seen0, bus0.joystick1, bus0.joystick2, bus0.present);
                    check_val("f1_strobe", {31'h0, seen1}, {31'h0, e.s1});
                    check_val("f1_joystick1", {16'h0, bus1.joystick1}, {16'h0, e.a1});
                    check_val("f1_joystick2", {16'h0, bus1.joystick2}, {16'h0, e.b1});
                    check_val("f1_present", {31'h0, bus1.present}, {31'h0, e.p1});
                    check_val("f0_strobe", {31'h0, seen0}, {31'h0, e.s0});
                    check_val("f0_joystick1", {16'h0, bus0.joystick1}, {16'h0, e.a0});
                    check_val("f0_joystick2", {16'h0, bus0.joystick2}, {16'h0, e.b0});
                    check_val("f0_present", {31'h0, bus0.present}, {31'h0, e.p0});
                    frame_no++;
                end
                seen1 = 1'b0;
                seen0 = 1'b0;
            end
            load_prev = bus1.joy_load;
        end
    end

    task automatic check_reset_state(input string tag);
        check_val({tag, "_joy_clk"}, {31'h0, bus1.joy_clk}, 32'h0);
        check_val({tag, "_joy_load"}, {31'h0, bus1.joy_load}, 32'h1);
        check_val({tag, "_f1_joy1"}, {16'h0, bus1.joystick1}, 32'h0);
        check_val({tag, "_f1_joy2"}, {16'h0, bus1.joystick2}, 32'h0);
        check_val({tag, "_f1_present"}, {31'h0, bus1.present}, 32'h0);
        check_val({tag, "_f1_strobe"}, {31'h0, bus1.frame_strobe}, 32'h0);
        check_val({tag, "_f0_joy_load"}, {31'h0, bus0.joy_load}, 32'h1);
        check_val({tag, "_f0_joy1"}, {16'h0, bus0.joystick1}, 32'h0);
        check_val({tag, "_f0_present"}, {31'h0, bus0.present}, 32'h0);
        check_val({tag, "_f0_strobe"}, {31'h0, bus0.frame_strobe}, 32'h0);
    endtask

    localparam logic [31:0] PA = 32'hFBFF_FFEE;  // P1 Right+A, P2 Start
    localparam logic [31:0] PG = 32'hFBFF_FFE6;  // PA with bit 3 (Up) glitched low
    localparam logic [31:0] PT = 32'hFBFF_0FEE;  // PA with ignored bits 15:12 flipped
    localparam logic [31:0] PB = 32'h5A5A_A5A5;
    localparam logic [31:0] PC = 32'hA5A5_5A5A;

    initial begin
        int n;
        int bad;
        int guard;

        pat = '{PA, PA, PA, PG, PA, PA, 32'h0, 32'h0, 32'h0, PT,
                PT, PA, PT, PB, PC, PB, PC, PA, PA, PA, PA};
        reset_model();
        next_pattern = pat[0];

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");

        // Frame 0: load/clock timing after reset release
        @(negedge clk);
        reset = 1'b0;
        wait_sig(1'b0, 1'b0, n);
        check_val("load_fall_delay", n, CLK_DIV);
        wait_sig(1'b0, 1'b1, n);
        check_val("load_low_clocks", n, 2 * CLK_DIV);
        push_frame(pat[0]);
        next_pattern = pat[1];
        bad = 0;
        for (int p = 0; p < 32; p++) begin
            wait_sig(1'b1, 1'b1, n);
            if (n != CLK_DIV) bad++;
            wait_sig(1'b1, 1'b0, n);
            if (n != CLK_DIV) bad++;
        end
        check_val("clk_pulse_timing_errors", bad, 0);
        check_val("load_high_after_pulses", {31'h0, bus1.joy_load}, 32'h1);

        for (int i = 1; i < 19; i++) begin
            wait_sig(1'b0, 1'b0, n);
            wait_sig(1'b0, 1'b1, n);
            push_frame(pat[i]);
            next_pattern = pat[i + 1];
        end

        // Frame 19 is aborted by reset during bit 17
        wait_sig(1'b0, 1'b0, n);
        wait_sig(1'b0, 1'b1, n);
        for (int k = 0; k < 17; k++) begin
            wait_sig(1'b1, 1'b1, n);
            wait_sig(1'b1, 1'b0, n);
        end
        wait_sig(1'b1, 1'b1, n);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state("midframe_reset");
        exp_q.delete();
        reset_model();
        next_pattern = pat[20];
        @(negedge clk);
        reset = 1'b0;
        wait_sig(1'b0, 1'b0, n);
        check_val("restart_load_delay", n, CLK_DIV);
        wait_sig(1'b0, 1'b1, n);
        push_frame(pat[20]);
        wait_sig(1'b0, 1'b0, n);
        wait_sig(1'b0, 1'b1, n);
        push_frame(pat[20]);

        guard = 0;
        while (exp_q.size() > 0 && guard < 2000) begin
            @(posedge clk);
            guard++;
        end
        check_val("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
